// File: rtl/cell_painter.sv
// cell_painter: sits between the clear-screen sweep and the VGA adapter write
// port. While the sweep runs it forwards sweep pixels as black writes,
// dropping off-screen coordinates. Once the sweep is done it accepts grid-cell
// paint requests and expands each one into CELL x CELL raster-ordered writes.
module cell_painter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int CELL     = 4,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          clr_x,
    input  logic [6:0]          clr_y,
    input  logic                clr_wren,
    input  logic                clr_done,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [5:0]          req_col,
    input  logic [4:0]          req_row,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic                req_err,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy
);

    // Offset counters need at least one bit even for a degenerate CELL of 1.
    localparam int LOG2_CELL = $clog2(CELL);
    localparam int DW        = (LOG2_CELL > 0) ? LOG2_CELL : 1;

    localparam logic [DW-1:0] D_LAST     = DW'(CELL - 1);
    localparam logic [7:0]    SCREEN_W_L = 8'(SCREEN_W);
    localparam logic [6:0]    SCREEN_H_L = 7'(SCREEN_H);
    localparam logic [5:0]    GRID_W_L   = 6'(GRID_W);
    localparam logic [4:0]    GRID_H_L   = 5'(GRID_H);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_PAINT
    } state_t;

    state_t                state_reg;
    logic [DW-1:0]         dx_reg;
    logic [DW-1:0]         dy_reg;
    logic [7:0]            base_x_reg;
    logic [6:0]            base_y_reg;
    logic [COLOUR_W-1:0]   colour_reg;

    logic                  clr_on_screen;
    logic                  req_in_grid;
    logic [7:0]            req_base_x;
    logic [6:0]            req_base_y;
    logic [7:0]            paint_x;
    logic [6:0]            paint_y;
    logic                  dx_last;
    logic                  dy_last;

    // Sweep pixels outside the visible area are never written.
    assign clr_on_screen = (clr_x < SCREEN_W_L) && (clr_y < SCREEN_H_L);

    // Requests outside the grid are rejected with an error pulse.
    assign req_in_grid   = (req_col < GRID_W_L) && (req_row < GRID_H_L);

    // Cell origin in pixels; in-range requests never overflow these widths.
    assign req_base_x    = 8'({2'b00, req_col} << LOG2_CELL);
    assign req_base_y    = 7'({2'b00, req_row} << LOG2_CELL);

    // Pixel currently being issued inside the latched cell.
    assign paint_x       = base_x_reg + 8'(dx_reg);
    assign paint_y       = base_y_reg + 7'(dy_reg);
    assign dx_last       = (dx_reg == D_LAST);
    assign dy_last       = (dy_reg == D_LAST);

    // A request can only be taken while idle with the sweep finished; a
    // restarted sweep (clr_done low) blocks acceptance in the same cycle.
    assign req_ready     = (state_reg == S_IDLE) && clr_done;
    assign busy          = (state_reg != S_IDLE);

    // Main sequencer: sweep forwarding, request acceptance and cell raster.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_CLEAR;
            dx_reg     <= '0;
            dy_reg     <= '0;
            base_x_reg <= '0;
            base_y_reg <= '0;
            colour_reg <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            // Strobes default low; each state raises what it needs.
            vga_plot <= 1'b0;
            req_err  <= 1'b0;

            case (state_reg)
                S_CLEAR: begin
                    // The pixel sampled on the exit edge is still forwarded.
                    vga_x      <= clr_x;
                    vga_y      <= clr_y;
                    vga_colour <= '0;
                    vga_plot   <= clr_wren && clr_on_screen;
                    if (clr_done) begin
                        state_reg <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (!clr_done) begin
                        state_reg <= S_CLEAR;
                    end else if (req_valid) begin
                        if (req_in_grid) begin
                            base_x_reg <= req_base_x;
                            base_y_reg <= req_base_y;
                            colour_reg <= req_colour;
                            dx_reg     <= '0;
                            dy_reg     <= '0;
                            state_reg  <= S_PAINT;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end

                S_PAINT: begin
                    // clr_done is deliberately ignored until the cell is done.
                    vga_x      <= paint_x;
                    vga_y      <= paint_y;
                    vga_colour <= colour_reg;
                    vga_plot   <= 1'b1;
                    if (dx_last) begin
                        dx_reg <= '0;
                        if (dy_last) begin
                            dy_reg    <= '0;
                            state_reg <= S_IDLE;
                        end else begin
                            dy_reg <= dy_reg + 1'b1;
                        end
                    end else begin
                        dx_reg <= dx_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_painter.sv
// Directed bench for cell_painter: table of sweep-edge vectors, a full sweep,
// then hand-written request sequences for the multi-cycle corner cases.
`timescale 1ns/1ps
module tb_cell_painter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] clr_x;
    logic [6:0] clr_y;
    logic       clr_wren;
    logic       clr_done;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_col;
    logic [4:0] req_row;
    logic [2:0] req_colour;
    logic       req_err;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    cell_painter dut (
        .clk        (clk),
        .reset      (reset),
        .clr_x      (clr_x),
        .clr_y      (clr_y),
        .clr_wren   (clr_wren),
        .clr_done   (clr_done),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_col    (req_col),
        .req_row    (req_row),
        .req_colour (req_colour),
        .req_err    (req_err),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Watchdog: the whole run is a few hundred microseconds.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       wren;
        logic       exp_plot;
    } sweep_vec_t;

    sweep_vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Follows the 16 plots of one cell after its acceptance edge.
    task automatic check_cell(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col,
                              input int drop_k, input logic exp_ready_end, input string name);
        int bad = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (vga_plot !== 1'b1 || vga_x !== bx + 8'((k - 1) % 4) ||
                vga_y !== by + 7'((k - 1) / 4) || vga_colour !== col)
                bad++;
            if (k < 16 && req_ready !== 1'b0)
                bad++;
            if (k == drop_k)
                clr_done = 1'b0;
        end
        check({name, " pixels"}, 32'(bad), 32'd0);
        check({name, " ready_end"}, 32'(req_ready), 32'(exp_ready_end));
        $display("cell %s base (%0d,%0d) colour %0d, bad pixels %0d", name, bx, by, col, bad);
    endtask

    initial begin
        int bad;
        int plots;

        vecs[0] = '{x: 8'd0,   y: 7'd0,   wren: 1'b1, exp_plot: 1'b1};
        vecs[1] = '{x: 8'd159, y: 7'd119, wren: 1'b1, exp_plot: 1'b1};
        vecs[2] = '{x: 8'd160, y: 7'd0,   wren: 1'b1, exp_plot: 1'b0};
        vecs[3] = '{x: 8'd0,   y: 7'd120, wren: 1'b1, exp_plot: 1'b0};
        vecs[4] = '{x: 8'd5,   y: 7'd5,   wren: 1'b0, exp_plot: 1'b0};
        vecs[5] = '{x: 8'd200, y: 7'd100, wren: 1'b1, exp_plot: 1'b0};
        vecs[6] = '{x: 8'd100, y: 7'd127, wren: 1'b1, exp_plot: 1'b0};
        vecs[7] = '{x: 8'd80,  y: 7'd60,  wren: 1'b1, exp_plot: 1'b1};

        reset = 1'b1; clr_x = 8'd33; clr_y = 7'd22; clr_wren = 1'b1; clr_done = 1'b0;
        req_valid = 1'b0; req_col = '0; req_row = '0; req_colour = '0;

        // Reset state
        tick(); tick();
        check("reset vga_plot", 32'(vga_plot), 32'd0);
        check("reset vga_x", 32'(vga_x), 32'd0);
        check("reset vga_y", 32'(vga_y), 32'd0);
        check("reset vga_colour", 32'(vga_colour), 32'd0);
        check("reset req_err", 32'(req_err), 32'd0);
        check("reset busy", 32'(busy), 32'd1);
        check("reset req_ready", 32'(req_ready), 32'd0);
        $display("reset: plot %0d x %0d y %0d busy %0d", vga_plot, vga_x, vga_y, busy);

        // Table-driven sweep vectors
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clr_x = vecs[i].x; clr_y = vecs[i].y; clr_wren = vecs[i].wren;
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'd0);
            tick();
            check($sformatf("vec%0d plot", i), 32'(vga_plot), 32'(vecs[i].exp_plot));
            check($sformatf("vec%0d x", i), 32'(vga_x), 32'(vecs[i].x));
            check($sformatf("vec%0d y", i), 32'(vga_y), 32'(vecs[i].y));
            check($sformatf("vec%0d colour", i), 32'(vga_colour), 32'd0);
            $display("sweep vec %0d: (%0d,%0d) wren %0d -> plot %0d", i, vecs[i].x, vecs[i].y,
                     vecs[i].wren, vga_plot);
        end

        // Full sweep over x=0..160, y=0..120
        bad = 0; plots = 0;
        for (int y = 0; y <= 120; y++) begin
            for (int x = 0; x <= 160; x++) begin
                clr_x = 8'(x); clr_y = 7'(y); clr_wren = 1'b1;
                if (req_ready !== 1'b0) bad++;
                tick();
                if (vga_plot !== ((x < 160) && (y < 120)) || vga_x !== 8'(x) ||
                    vga_y !== 7'(y) || vga_colour !== 3'd0)
                    bad++;
                if (vga_plot === 1'b1) plots++;
            end
        end
        check("sweep plot count", 32'(plots), 32'd19200);
        check("sweep pixel errors", 32'(bad), 32'd0);
        $display("full sweep: %0d plots, %0d bad cycles", plots, bad);

        // Sweep completes: the pixel on the exit edge is still forwarded
        clr_x = 8'd10; clr_y = 7'd10; clr_wren = 1'b1; clr_done = 1'b1;
        tick();
        check("done edge plot", 32'(vga_plot), 32'd1);
        check("done edge x", 32'(vga_x), 32'd10);
        clr_wren = 1'b0;
        check("idle req_ready", 32'(req_ready), 32'd1);
        check("idle busy", 32'(busy), 32'd0);
        tick();
        check("idle plot", 32'(vga_plot), 32'd0);

        // Bottom-right cell
        req_valid = 1'b1; req_col = 6'd39; req_row = 5'd29; req_colour = 3'b100;
        tick();
        req_valid = 1'b0;
        check_cell(8'd156, 7'd116, 3'b100, 0, 1'b1, "c39r29");
        tick();
        check("after c39r29 plot", 32'(vga_plot), 32'd0);

        // Back-to-back with req_valid held
        req_valid = 1'b1; req_col = 6'd0; req_row = 5'd0; req_colour = 3'b010;
        tick();
        req_col = 6'd1;
        check_cell(8'd0, 7'd0, 3'b010, 0, 1'b1, "b2b_first");
        tick();
        check("b2b gap plot", 32'(vga_plot), 32'd0);
        req_valid = 1'b0;
        check_cell(8'd4, 7'd0, 3'b010, 0, 1'b1, "b2b_second");
        tick();

        // Out-of-range requests
        req_valid = 1'b1; req_col = 6'd40; req_row = 5'd0; req_colour = 3'b111;
        check("err1 req_ready", 32'(req_ready), 32'd1);
        tick();
        check("err1 req_err", 32'(req_err), 32'd1);
        check("err1 plot", 32'(vga_plot), 32'd0);
        req_col = 6'd0; req_row = 5'd30;
        check("err2 req_ready", 32'(req_ready), 32'd1);
        tick();
        check("err2 req_err", 32'(req_err), 32'd1);
        check("err2 plot", 32'(vga_plot), 32'd0);
        req_valid = 1'b0;
        tick();
        check("err pulse ends", 32'(req_err), 32'd0);
        check("err no plot", 32'(vga_plot), 32'd0);
        check("err busy", 32'(busy), 32'd0);
        $display("out-of-range requests (40,0) and (0,30) rejected");

        // Colour 0 erases a cell
        req_valid = 1'b1; req_col = 6'd10; req_row = 5'd10; req_colour = 3'b000;
        tick();
        req_valid = 1'b0;
        check_cell(8'd40, 7'd40, 3'b000, 0, 1'b1, "erase");
        tick();

        // Drop clr_done mid-paint with a request pending
        req_valid = 1'b1; req_col = 6'd2; req_row = 5'd3; req_colour = 3'b101;
        tick();
        req_col = 6'd3;
        check_cell(8'd8, 7'd12, 3'b101, 5, 1'b0, "drop");
        check("drop idle busy", 32'(busy), 32'd0);
        tick();
        check("drop to clear busy", 32'(busy), 32'd1);
        check("drop to clear plot", 32'(vga_plot), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (req_ready !== 1'b0) bad++;
            tick();
            if (vga_plot !== 1'b0) bad++;
        end
        check("pending held off", 32'(bad), 32'd0);
        clr_done = 1'b1;
        check("pending ready in clear", 32'(req_ready), 32'd0);
        tick();
        check("re-idle plot", 32'(vga_plot), 32'd0);
        check("pending ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_cell(8'd12, 7'd12, 3'b101, 0, 1'b1, "pending");
        tick();

        // Reset at the 7th plot of a cell
        req_valid = 1'b1; req_col = 6'd5; req_row = 5'd5; req_colour = 3'b001;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        check("7th plot strobe", 32'(vga_plot), 32'd1);
        check("7th plot x", 32'(vga_x), 32'd22);
        check("7th plot y", 32'(vga_y), 32'd21);
        reset = 1'b1;
        tick();
        check("midreset plot", 32'(vga_plot), 32'd0);
        check("midreset x", 32'(vga_x), 32'd0);
        check("midreset y", 32'(vga_y), 32'd0);
        check("midreset colour", 32'(vga_colour), 32'd0);
        check("midreset req_err", 32'(req_err), 32'd0);
        check("midreset busy", 32'(busy), 32'd1);
        check("midreset req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0; clr_done = 1'b0; clr_wren = 1'b0;
        plots = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (vga_plot === 1'b1) plots++;
        end
        check("post-reset plots", 32'(plots), 32'd0);
        check("post-reset busy", 32'(busy), 32'd1);
        $display("mid-paint reset: %0d stray plots after release", plots);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cell_painter.md
Name: cell_painter

Overview:
- Sits directly downstream of the clear-screen sweep stage and directly upstream of the VGA adapter write port.
- While the sweep runs, it forwards the sweep's pixel stream as black writes, with range filtering.
- Once the sweep reports done, it accepts grid-cell paint requests (snake segment, food, erase) over a valid/ready handshake.
- Each accepted request is expanded into CELL×CELL consecutive pixel writes.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- CELL, 4, cell edge in pixels (power of two).
- GRID_W, 40, grid columns (SCREEN_W/CELL).
- GRID_H, 30, grid rows (SCREEN_H/CELL).
- COLOUR_W, 3, colour bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clr_x  in  8  sweep pixel x.
- clr_y  in  7  sweep pixel y.
- clr_wren  in  1  sweep pixel valid.
- clr_done  in  1  high once the sweep has finished; low while sweeping.
- req_valid  in  1  paint request valid.
- req_ready  out  1  paint request accepted this cycle if req_valid.
- req_col  in  6  grid column.
- req_row  in  5  grid row.
- req_colour  in  COLOUR_W  cell colour.
- req_err  out  1  one-cycle pulse: an accepted request was out of range.
- vga_x  out  8  pixel x to adapter.
- vga_y  out  7  pixel y to adapter.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  write strobe.
- busy  out  1  high in S_CLEAR or S_PAINT.

Behaviour:
- Clock and reset: one clock, synchronous active-high reset. All outputs are registered except req_ready and busy, which decode state combinationally.
- Reset values: state=S_CLEAR; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, req_err=0. Internal dx, dy, base and colour registers are cleared.
- Reset mid-paint: the current cell is abandoned with no further plots. The first plot after reset release can come only from the sweep stream.
- States: S_CLEAR, S_IDLE, S_PAINT.
- S_CLEAR:
  - Each cycle registers vga_x<=clr_x, vga_y<=clr_y, vga_colour<=0.
  - vga_plot<=clr_wren && clr_x<SCREEN_W && clr_y<SCREEN_H. Coordinates x≥160 or y≥120 are dropped.
  - req_ready=0.
  - clr_done=1 moves to S_IDLE on the next edge. The pixel sampled on that edge is still forwarded under the same rules.
- S_IDLE:
  - vga_plot<=0.
  - req_ready = clr_done.
  - clr_done=0 moves to S_CLEAR. A restarted sweep has priority over any pending request, which stays unaccepted.
  - req_valid && req_ready accepts the request.
    - If req_col<GRID_W and req_row<GRID_H: latch base_x=req_col*CELL, base_y=req_row*CELL and req_colour, reset dx=dy=0, go to S_PAINT.
    - Otherwise: pulse req_err for one cycle, stay in S_IDLE, produce no plots. req_ready stays high, so back-to-back requests are possible.
- S_PAINT:
  - Each cycle registers vga_x<=base_x+dx, vga_y<=base_y+dy, vga_colour<=latched colour, vga_plot<=1.
  - dx increments each cycle; at dx=CELL-1 it wraps to 0 and dy increments.
  - After issuing (CELL-1, CELL-1), go to S_IDLE.
  - req_ready=0 throughout. clr_done is ignored until the cell completes, then honoured from S_IDLE.
- Timing:
  - Acceptance at edge N gives vga_plot=1 for edges N+1 through N+CELL², i.e. exactly 16 cycles at CELL=4, raster order within the cell.
  - req_ready is high again in the cycle after edge N+CELL².
  - One request costs CELL²+1 cycles.
- Arithmetic: base_x = req_col shifted left by log2(CELL), truncated to 8 bits; base_y likewise to 7 bits. In-range requests never overflow; max pixel (159,119).
- Colour 0 requests are legal: they erase a cell, e.g. the tail.

Test Plan:
- Reset, then sweep stream with clr_wren=1 over x=0..160, y=0..120 -> vga_plot high for exactly 19,200 pixels, colour 0. No plot for x=160 or y=120. req_ready=0 throughout.
- clr_done=1, request col=39 row=29 colour=3'b100 -> vga_plot for 16 cycles, x 156..159 by y 116..119 in raster order, colour 100. req_ready low for 16 cycles, then high.
- Back-to-back requests (0,0,3'b010) then (1,0,3'b010) with req_valid held -> 32 contiguous plots minus one idle cycle between cells. Second cell covers x 4..7, y 0..3.
- Request col=40 row=0 -> req_err pulses one cycle, zero plots, req_ready stays high. Then col=0 row=30 -> same.
- Drop clr_done mid-paint -> the current cell finishes all 16 plots, then state returns to S_CLEAR. A pending req_valid is not accepted until clr_done=1 again.
- Assert reset at the 7th plot of a cell -> vga_plot=0 and all outputs 0 the next cycle, state S_CLEAR, no remaining cell pixels emitted.
